// File: rtl/fpu_cmd_sequencer.sv
// Host-side command queue and four-phase start/done initiator for the FPU core.
// Commands are issued one at a time; each result waits on a valid/ready channel.
//
// state          | meaning
// SEQ_IDLE       | waiting for a queued command, pops one when available
// SEQ_WAIT_DONE  | fpu_start high, waiting for fpu_done to rise
// SEQ_RELEASE    | fpu_start low, waiting for fpu_done to fall
// SEQ_OUTPUT     | res_valid high, holding result until res_ready
module fpu_cmd_sequencer #(
    parameter int W              = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk_i,
    input  logic                          arst_i,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [3:0]                    cmd_op_i,
    input  logic [W-1:0]                  cmd_a_i,
    input  logic [W-1:0]                  cmd_b_i,
    output logic                          res_valid_o,
    input  logic                          res_ready_i,
    output logic [W-1:0]                  res_data_o,
    output logic [3:0]                    res_op_o,
    output logic [1:0]                    res_err_o,
    output logic                          fpu_start_o,
    output logic [3:0]                    fpu_op_o,
    output logic [W-1:0]                  fpu_a_o,
    output logic [W-1:0]                  fpu_b_o,
    input  logic                          fpu_done_i,
    input  logic [W-1:0]                  fpu_result_i,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [AW:0]   DEPTH_L  = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] SEQ_IDLE      = 2'd0;
    localparam logic [1:0] SEQ_WAIT_DONE = 2'd1;
    localparam logic [1:0] SEQ_RELEASE   = 2'd2;
    localparam logic [1:0] SEQ_OUTPUT    = 2'd3;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [3:0] OP_ILLEGAL  = 4'hF;

    logic [3:0]   q_op [FIFO_DEPTH];
    logic [W-1:0] q_a  [FIFO_DEPTH];
    logic [W-1:0] q_b  [FIFO_DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          push, pop;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic          fpu_start_q, fpu_start_d;
    logic [3:0]    fpu_op_q, fpu_op_d;
    logic [W-1:0]  fpu_a_q, fpu_a_d;
    logic [W-1:0]  fpu_b_q, fpu_b_d;
    logic          res_valid_q, res_valid_d;
    logic [W-1:0]  res_data_q, res_data_d;
    logic [1:0]    res_err_q, res_err_d;

    // Ready is registered from the next level, so a full queue never bypasses.
    always_comb begin
        push        = cmd_valid_i && cmd_ready_q;
        pop         = (state_q == SEQ_IDLE) && (level_q != '0);
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d     = level_q + (AW+1)'(push) - (AW+1)'(pop);
        cmd_ready_d = level_d < DEPTH_L;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_op[wr_ptr_q] <= cmd_op_i;
            q_a[wr_ptr_q]  <= cmd_a_i;
            q_b[wr_ptr_q]  <= cmd_b_i;
        end
    end

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        fpu_start_d = fpu_start_q;
        fpu_op_d    = fpu_op_q;
        fpu_a_d     = fpu_a_q;
        fpu_b_d     = fpu_b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;

        case (state_q)
            SEQ_IDLE: begin
                if (pop) begin
                    fpu_op_d   = q_op[rd_ptr_q];
                    fpu_a_d    = q_a[rd_ptr_q];
                    fpu_b_d    = q_b[rd_ptr_q];
                    res_data_d = '0;
                    if (q_op[rd_ptr_q] == OP_ILLEGAL) begin
                        res_err_d   = ERR_ILLEGAL;
                        res_valid_d = 1'b1;
                        state_d     = SEQ_OUTPUT;
                    end else begin
                        res_err_d   = ERR_OK;
                        fpu_start_d = 1'b1;
                        state_d     = SEQ_WAIT_DONE;
                    end
                end
            end
            SEQ_WAIT_DONE: begin
                if (fpu_done_i) begin
                    res_data_d  = fpu_result_i;
                    fpu_start_d = 1'b0;
                    state_d     = SEQ_RELEASE;
                end else if (tmo_q == TMO_LAST) begin
                    res_data_d  = '0;
                    res_err_d   = ERR_TIMEOUT;
                    fpu_start_d = 1'b0;
                    state_d     = SEQ_RELEASE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            SEQ_RELEASE: begin
                if (!fpu_done_i) begin
                    res_valid_d = 1'b1;
                    state_d     = SEQ_OUTPUT;
                end else if (tmo_q == TMO_LAST) begin
                    res_data_d  = '0;
                    res_err_d   = ERR_TIMEOUT;
                    res_valid_d = 1'b1;
                    state_d     = SEQ_OUTPUT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            SEQ_OUTPUT: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = SEQ_IDLE;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase

        // Each handshake phase gets its own full timeout window.
        if (state_d != state_q) tmo_d = '0;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cmd_ready_q <= 1'b1;
            state_q     <= SEQ_IDLE;
            tmo_q       <= '0;
            fpu_start_q <= 1'b0;
            fpu_op_q    <= '0;
            fpu_a_q     <= '0;
            fpu_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            cmd_ready_q <= cmd_ready_d;
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            fpu_start_q <= fpu_start_d;
            fpu_op_q    <= fpu_op_d;
            fpu_a_q     <= fpu_a_d;
            fpu_b_q     <= fpu_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
        end
    end

    assign cmd_ready_o  = cmd_ready_q;
    assign res_valid_o  = res_valid_q;
    assign res_data_o   = res_data_q;
    assign res_op_o     = fpu_op_q;
    assign res_err_o    = res_err_q;
    assign fpu_start_o  = fpu_start_q;
    assign fpu_op_o     = fpu_op_q;
    assign fpu_a_o      = fpu_a_q;
    assign fpu_b_o      = fpu_b_q;
    assign busy_o       = (state_q != SEQ_IDLE) || (level_q != '0);
    assign fifo_level_o = level_q;

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// Bench for fpu_cmd_sequencer: behavioural FPU responder, result scoreboard,
// directed handshake/latency/reset scenarios and a randomized command stream.
module tb_fpu_cmd_sequencer;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int TMO   = 32;

    logic        clk, arst;
    logic        cmd_valid, cmd_ready;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_a, cmd_b;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [3:0]  res_op;
    logic [1:0]  res_err;
    logic        fpu_start, fpu_done;
    logic [3:0]  fpu_op;
    logic [31:0] fpu_a, fpu_b, fpu_result;
    logic        busy;
    logic [2:0]  fifo_level;

    fpu_cmd_sequencer #(.W(W), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .arst_i(arst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_data_o(res_data), .res_op_o(res_op), .res_err_o(res_err),
        .fpu_start_o(fpu_start), .fpu_op_o(fpu_op), .fpu_a_o(fpu_a), .fpu_b_o(fpu_b),
        .fpu_done_i(fpu_done), .fpu_result_i(fpu_result),
        .busy_o(busy), .fifo_level_o(fifo_level)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  op;
        logic [1:0]  err;
    } res_t;

    res_t expq[$];
    int   total = 0;
    int   bad   = 0;
    int   starts = 0;
    int   rr_mode = 1;        // 0 ready low, 1 ready high, 2 random
    int   fpu_lat = 5;
    int   fpu_rel = 1;
    bit   fpu_hang = 0;
    bit   fpu_rand = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Stand-in FPU arithmetic; the sequencer only has to carry the value through.
    function automatic logic [31:0] fpu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        if (op == 4'h0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return (a ^ {b[15:0], b[31:16]}) + {28'd0, op};
    endfunction

    // FPU responder: four-phase handshake with configurable done/release delays.
    initial begin
        int st = 0;
        int cnt = 0;
        int lat = 0;
        int rel = 0;
        bit first = 0;
        logic [3:0]  op_l;
        logic [31:0] a_l, b_l;
        fpu_done = 1'b0;
        fpu_result = '0;
        forever begin
            @(negedge clk);
            if (arst) begin
                st = 0;
                fpu_done = 1'b0;
                fpu_result = '0;
            end else begin
                if (st >= 1 && st <= 3) begin
                    check("fpu_op_hold", {28'd0, fpu_op}, {28'd0, op_l});
                    check("fpu_a_hold", fpu_a, a_l);
                    check("fpu_b_hold", fpu_b, b_l);
                end
                case (st)
                    0: if (fpu_start) begin
                        starts++;
                        op_l = fpu_op; a_l = fpu_a; b_l = fpu_b;
                        cnt = 0;
                        lat = fpu_rand ? int'($urandom_range(1, 6)) : fpu_lat;
                        rel = fpu_rand ? int'($urandom_range(0, 3)) : fpu_rel;
                        st = 1;
                    end
                    1: begin
                        if (!fpu_start) st = 0;
                        else if (!fpu_hang) begin
                            cnt++;
                            if (cnt >= lat) begin
                                fpu_done = 1'b1;
                                fpu_result = fpu_fn(op_l, a_l, b_l);
                                first = 1;
                                st = 2;
                            end
                        end
                    end
                    2: begin
                        if (first) begin
                            check("start_fall_lat", {31'd0, fpu_start}, 32'd0);
                            first = 0;
                        end
                        if (!fpu_start) begin
                            cnt = 0;
                            st = 3;
                        end
                    end
                    3: begin
                        cnt++;
                        if (cnt > rel) begin
                            fpu_done = 1'b0;
                            fpu_result = '0;
                            st = (rel < TMO) ? 4 : 0;
                        end
                    end
                    default: begin
                        check("res_valid_lat", {31'd0, res_valid}, 32'd1);
                        st = 0;
                    end
                endcase
            end
        end
    end

    // Result sink: drives res_ready, checks hold stability and scoreboard order.
    initial begin
        bit held = 0;
        logic [31:0] hd;
        logic [3:0]  ho;
        logic [1:0]  he;
        res_t e;
        res_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (arst) begin
                held = 0;
                res_ready = 1'b0;
            end else begin
                res_ready = (rr_mode == 2) ? ($urandom_range(0, 1) == 1) : (rr_mode == 1);
                if (held && res_valid) begin
                    check("res_data_hold", res_data, hd);
                    check("res_op_hold", {28'd0, res_op}, {28'd0, ho});
                    check("res_err_hold", {30'd0, res_err}, {30'd0, he});
                end
                if (res_valid && res_ready) begin
                    check("result_expected", {31'd0, expq.size() > 0}, 32'd1);
                    if (expq.size() > 0) begin
                        e = expq.pop_front();
                        check("res_data", res_data, e.data);
                        check("res_op", {28'd0, res_op}, {28'd0, e.op});
                        check("res_err", {30'd0, res_err}, {30'd0, e.err});
                    end
                end
                held = res_valid && !res_ready;
                hd = res_data; ho = res_op; he = res_err;
            end
        end
    end

    // Drives a command and returns at the negedge after it was accepted.
    task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        res_t e;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("push_accept", {31'd0, cmd_ready}, 32'd1);
        e.op = op;
        if (op == 4'hF) begin
            e.err = 2'b01; e.data = '0;
        end else if (fpu_hang || (!fpu_rand && fpu_rel >= TMO)) begin
            e.err = 2'b10; e.data = '0;
        end else begin
            e.err = 2'b00; e.data = fpu_fn(op, a, b);
        end
        expq.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (expq.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", expq.size(), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        int s0;
        logic [31:0] hd;
        logic [3:0]  ho;
        arst = 1'b1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_fpu_start", {31'd0, fpu_start}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_level", {29'd0, fifo_level}, 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_res_err", {30'd0, res_err}, 32'd0);
        arst = 1'b0;
        @(negedge clk);

        // basic add with start-latency and four-phase order checks
        push(4'h0, 32'h3F80_0000, 32'h4000_0000);
        cmd_valid = 1'b0;
        check("t1_start_n1", {31'd0, fpu_start}, 32'd0);
        check("t1_level", {29'd0, fifo_level}, 32'd1);
        @(negedge clk);
        check("t1_start_n2", {31'd0, fpu_start}, 32'd1);
        check("t1_busy", {31'd0, busy}, 32'd1);
        drain(100);

        // illegal opcode bypasses the FPU
        s0 = starts;
        push(4'hF, $urandom, $urandom);
        cmd_valid = 1'b0;
        check("t3_valid_n1", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        check("t3_valid_n2", {31'd0, res_valid}, 32'd1);
        check("t3_err", {30'd0, res_err}, 32'd1);
        check("t3_data", res_data, 32'd0);
        drain(50);
        check("t3_no_start", starts, s0);

        // queue fills while the FPU is slow; order preserved
        fpu_lat = 20;
        for (int k = 0; k < 5; k++) push(4'(k + 1), $urandom, $urandom);
        check("t2_ready_full", {31'd0, cmd_ready}, 32'd0);
        check("t2_level_full", {29'd0, fifo_level}, 32'd4);
        push(4'h6, $urandom, $urandom);
        cmd_valid = 1'b0;
        drain(600);
        fpu_lat = 5;

        // FPU never answers: start held exactly TMO cycles, then next command runs
        fpu_hang = 1;
        push(4'h2, $urandom, $urandom);
        cmd_valid = 1'b0;
        cnt = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (fpu_start) cnt++;
            else if (cnt > 0) break;
        end
        check("t4_start_len", cnt, TMO);
        drain(50);
        fpu_hang = 0;
        push(4'h3, $urandom, $urandom);
        cmd_valid = 1'b0;
        drain(100);

        // done stuck high after start falls: release phase times out
        fpu_lat = 3;
        fpu_rel = 100;
        push(4'h4, $urandom, $urandom);
        cmd_valid = 1'b0;
        drain(200);
        for (int n = 0; n < 300 && fpu_done; n++) @(negedge clk);
        check("t4b_done_low", {31'd0, fpu_done}, 32'd0);
        fpu_rel = 1;
        @(negedge clk);

        // result backpressure holds outputs and blocks the next issue
        rr_mode = 0;
        push(4'h5, $urandom, $urandom);
        push(4'h6, $urandom, $urandom);
        cmd_valid = 1'b0;
        for (int n = 0; n < 100 && !res_valid; n++) @(negedge clk);
        check("t5_valid", {31'd0, res_valid}, 32'd1);
        hd = res_data;
        ho = res_op;
        repeat (10) begin
            @(negedge clk);
            check("t5_data_stable", res_data, hd);
            check("t5_op_stable", {28'd0, res_op}, {28'd0, ho});
            check("t5_no_start", {31'd0, fpu_start}, 32'd0);
        end
        rr_mode = 1;
        for (int n = 0; n < 20 && !fpu_start; n++) @(negedge clk);
        check("t5_next_issue", {31'd0, fpu_start}, 32'd1);
        drain(100);

        // randomized stream with random FPU timing and host backpressure
        fpu_rand = 1;
        rr_mode = 2;
        for (int i = 0; i < 40; i++) begin
            cmd_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            push(4'($urandom_range(0, 15)), $urandom, $urandom);
        end
        cmd_valid = 1'b0;
        drain(3000);
        fpu_rand = 0;
        rr_mode = 1;

        // asynchronous reset mid-handshake
        fpu_hang = 1;
        push(4'h7, $urandom, $urandom);
        push(4'h8, $urandom, $urandom);
        push(4'h9, $urandom, $urandom);
        cmd_valid = 1'b0;
        for (int n = 0; n < 20 && !fpu_start; n++) @(negedge clk);
        check("t6_start_before", {31'd0, fpu_start}, 32'd1);
        #2 arst = 1'b1;
        #1;
        check("t6_start_drop", {31'd0, fpu_start}, 32'd0);
        check("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("t6_level", {29'd0, fifo_level}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_res_valid", {31'd0, res_valid}, 32'd0);
        expq.delete();
        @(negedge clk);
        arst = 1'b0;
        fpu_hang = 0;
        @(negedge clk);
        push(4'h1, $urandom, $urandom);
        cmd_valid = 1'b0;
        drain(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
